// File: rtl/trap_seq.sv
// ---------------------------------------------------------------------------
// trap_seq : machine-mode trap sequencer
//
// Sits beside the pipeline controller. It recognises ecall, ebreak, mret and
// enabled external interrupts. It stalls the pipeline while it updates the
// trap CSRs one per cycle (mepc, mcause, mstatus, or just mstatus for mret).
// It then redirects fetch with a one-cycle strobe.
//
// Ports
//   clk_i        core clock
//   rst_i        synchronous active-high reset
//   inst_i       instruction currently in ID
//   inst_addr_i  address of inst_i
//   jump_flag_i  EX redirect this cycle
//   jump_addr_i  EX redirect target
//   div_busy_i   multi-cycle divider in flight
//   int_req_i    level interrupt requests, bit0 highest priority
//   mtvec_i      current mtvec
//   mepc_i       current mepc
//   mstatus_i    current mstatus (bit3 MIE, bit7 MPIE)
//   hold_flag_o  stall request to the pipeline controller
//   csr_we_o     CSR write enable
//   csr_waddr_o  CSR write address
//   csr_wdata_o  CSR write data
//   int_assert_o one-cycle redirect strobe
//   int_addr_o   redirect target, valid while int_assert_o is high
// ---------------------------------------------------------------------------
module trap_seq #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int INT_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       inst_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    input  logic              jump_flag_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              div_busy_i,
    input  logic [INT_W-1:0]  int_req_i,
    input  logic [DATA_W-1:0] mtvec_i,
    input  logic [DATA_W-1:0] mepc_i,
    input  logic [DATA_W-1:0] mstatus_i,
    output logic              hold_flag_o,
    output logic              csr_we_o,
    output logic [11:0]       csr_waddr_o,
    output logic [DATA_W-1:0] csr_wdata_o,
    output logic              int_assert_o,
    output logic [ADDR_W-1:0] int_addr_o
);

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [DATA_W-1:0] CAUSE_ECALL    = DATA_W'(11);
    localparam logic [DATA_W-1:0] CAUSE_EBREAK   = DATA_W'(3);
    localparam logic [DATA_W-1:0] CAUSE_IRQ_BASE = DATA_W'(32'h8000_0010);

    localparam int IDX_W = (INT_W > 1) ? $clog2(INT_W) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_MEPC,
        ST_MCAUSE,
        ST_MSTATUS,
        ST_MRET,
        ST_ASSERT
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] cause_q, cause_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic              isMret_q, isMret_d;

    logic              csrWe_q, csrWe_d;
    logic [11:0]       csrWaddr_q, csrWaddr_d;
    logic [DATA_W-1:0] csrWdata_q, csrWdata_d;
    logic              intAssert_q, intAssert_d;
    logic [ADDR_W-1:0] intAddr_q, intAddr_d;

    logic              isEcall;
    logic              isEbreak;
    logic              isMret;
    logic              syncTrap;
    logic              intPending;
    logic              eventValid;
    logic [IDX_W-1:0]  irqIdx;
    logic [DATA_W-1:0] irqCause;

    // Instruction decode and interrupt qualification. Reset masks the event
    // so that nothing is requested while the sequencer is being cleared.
    always_comb begin
        isEcall    = (inst_i == INST_ECALL);
        isEbreak   = (inst_i == INST_EBREAK);
        isMret     = (inst_i == INST_MRET);
        syncTrap   = isEcall | isEbreak;
        intPending = (|int_req_i) & mstatus_i[3];
        eventValid = ~rst_i & (syncTrap | isMret | intPending);
    end

    // Lowest-numbered request wins. The loop runs downwards, so the last hit
    // that is kept is the lowest set bit.
    always_comb begin
        irqIdx = '0;
        for (int i = INT_W - 1; i >= 0; i--) begin
            if (int_req_i[i]) begin
                irqIdx = IDX_W'(i);
            end
        end
    end

    assign irqCause = CAUSE_IRQ_BASE + DATA_W'(irqIdx);

    // Next-state logic.
    // Only the IDLE state looks at events. Cause, epc and kind are frozen
    // from then on, so later input changes cannot disturb a sequence.
    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        epc_d    = epc_q;
        isMret_d = isMret_q;

        case (state_q)
            ST_IDLE: begin
                if (eventValid) begin
                    if (syncTrap) begin
                        cause_d  = isEcall ? CAUSE_ECALL : CAUSE_EBREAK;
                        epc_d    = inst_addr_i;
                        isMret_d = 1'b0;
                    end else if (isMret) begin
                        isMret_d = 1'b1;
                    end else begin
                        cause_d  = irqCause;
                        epc_d    = jump_flag_i ? jump_addr_i : inst_addr_i;
                        isMret_d = 1'b0;
                    end

                    if (div_busy_i) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = isMret_d ? ST_MRET : ST_MEPC;
                    end
                end
            end

            ST_WAIT: begin
                if (!div_busy_i) begin
                    state_d = isMret_q ? ST_MRET : ST_MEPC;
                end
            end

            ST_MEPC:    state_d = ST_MCAUSE;
            ST_MCAUSE:  state_d = ST_MSTATUS;
            ST_MSTATUS: state_d = ST_ASSERT;
            ST_MRET:    state_d = ST_ASSERT;
            ST_ASSERT:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Registered outputs are computed from the state being entered. The
    // registers then hold exactly what that state drives while it is
    // current. The redirect target is captured on the edge into ASSERT.
    always_comb begin
        csrWe_d     = 1'b0;
        csrWaddr_d  = '0;
        csrWdata_d  = '0;
        intAssert_d = 1'b0;
        intAddr_d   = '0;

        case (state_d)
            ST_MEPC: begin
                csrWe_d    = 1'b1;
                csrWaddr_d = CSR_MEPC;
                csrWdata_d = DATA_W'(epc_d);
            end

            ST_MCAUSE: begin
                csrWe_d    = 1'b1;
                csrWaddr_d = CSR_MCAUSE;
                csrWdata_d = cause_d;
            end

            ST_MSTATUS: begin
                csrWe_d       = 1'b1;
                csrWaddr_d    = CSR_MSTATUS;
                csrWdata_d    = mstatus_i;
                csrWdata_d[7] = mstatus_i[3];
                csrWdata_d[3] = 1'b0;
            end

            ST_MRET: begin
                csrWe_d       = 1'b1;
                csrWaddr_d    = CSR_MSTATUS;
                csrWdata_d    = mstatus_i;
                csrWdata_d[3] = mstatus_i[7];
                csrWdata_d[7] = 1'b1;
            end

            ST_ASSERT: begin
                intAssert_d = 1'b1;
                intAddr_d   = (state_q == ST_MRET) ? ADDR_W'(mepc_i)
                                                   : ADDR_W'(mtvec_i);
            end

            default: begin
            end
        endcase
    end

    // State, latched trap information and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cause_q     <= '0;
            epc_q       <= '0;
            isMret_q    <= 1'b0;
            csrWe_q     <= 1'b0;
            csrWaddr_q  <= '0;
            csrWdata_q  <= '0;
            intAssert_q <= 1'b0;
            intAddr_q   <= '0;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            epc_q       <= epc_d;
            isMret_q    <= isMret_d;
            csrWe_q     <= csrWe_d;
            csrWaddr_q  <= csrWaddr_d;
            csrWdata_q  <= csrWdata_d;
            intAssert_q <= intAssert_d;
            intAddr_q   <= intAddr_d;
        end
    end

    // The stall must reach the pipeline in the same cycle an event is seen.
    // For that reason the stall is combinational and not registered.
    assign hold_flag_o  = (state_q != ST_IDLE) | ((state_q == ST_IDLE) & eventValid);

    assign csr_we_o     = csrWe_q;
    assign csr_waddr_o  = csrWaddr_q;
    assign csr_wdata_o  = csrWdata_q;
    assign int_assert_o = intAssert_q;
    assign int_addr_o   = intAddr_q;

endmodule

// File: tb/tb_trap_seq.sv
// ---------------------------------------------------------------------------
// tb_trap_seq : testbench for trap_seq
//
// For each event, the bench works out from the trap rules what the whole
// output trace should be: a detect cycle, then divider wait cycles, then the
// CSR writes, then the redirect strobe. It compares that trace cycle by
// cycle. A small CSR model feeds the written mstatus/mepc back one cycle
// later, as the real CSR file would.
// ---------------------------------------------------------------------------
module tb_trap_seq;

    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] inst_i;
    logic [31:0] inst_addr_i;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        div_busy_i;
    logic [7:0]  int_req_i;
    logic [31:0] mtvec_i;
    logic [31:0] mepc_i;
    logic [31:0] mstatus_i;
    logic        hold_flag_o;
    logic        csr_we_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;
    logic        int_assert_o;
    logic [31:0] int_addr_o;

    typedef struct {
        logic        hold;
        logic        we;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic        as;
        logic [31:0] aaddr;
    } expRec_t;

    expRec_t     expQ[$];
    logic [31:0] mstatusReg;
    logic [31:0] mepcReg;
    logic [31:0] mtvecReg;
    int          vectors     = 0;
    int          miscompares = 0;

    always #5 clk_i = ~clk_i;

    trap_seq #(
        .ADDR_W(32),
        .DATA_W(32),
        .INT_W (8)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .inst_i      (inst_i),
        .inst_addr_i (inst_addr_i),
        .jump_flag_i (jump_flag_i),
        .jump_addr_i (jump_addr_i),
        .div_busy_i  (div_busy_i),
        .int_req_i   (int_req_i),
        .mtvec_i     (mtvec_i),
        .mepc_i      (mepc_i),
        .mstatus_i   (mstatus_i),
        .hold_flag_o (hold_flag_o),
        .csr_we_o    (csr_we_o),
        .csr_waddr_o (csr_waddr_o),
        .csr_wdata_o (csr_wdata_o),
        .int_assert_o(int_assert_o),
        .int_addr_o  (int_addr_o)
    );

    function automatic expRec_t mkRec(input logic h, input logic w, input logic [11:0] a,
                                      input logic [31:0] d, input logic s, input logic [31:0] t);
        expRec_t r;
        r.hold  = h;
        r.we    = w;
        r.waddr = a;
        r.wdata = d;
        r.as    = s;
        r.aaddr = t;
        return r;
    endfunction

    // Drive one cycle of inputs. The CSR values always come from the CSR model.
    task automatic applyStimulus(input logic [31:0] inst, input logic [31:0] addr,
                                 input logic jf, input logic [31:0] ja,
                                 input logic busy, input logic [7:0] irq);
        inst_i      = inst;
        inst_addr_i = addr;
        jump_flag_i = jf;
        jump_addr_i = ja;
        div_busy_i  = busy;
        int_req_i   = irq;
        mstatus_i   = mstatusReg;
        mtvec_i     = mtvecReg;
        mepc_i      = mepcReg;
    endtask

    task automatic checkOutput(input string tag, input expRec_t e);
        vectors++;
        assert (hold_flag_o === e.hold) else begin
            miscompares++;
            $error("[TB] FAIL %s hold_flag_o got %0h want %0h", tag, hold_flag_o, e.hold);
        end
        vectors++;
        assert (csr_we_o === e.we) else begin
            miscompares++;
            $error("[TB] FAIL %s csr_we_o got %0h want %0h", tag, csr_we_o, e.we);
        end
        vectors++;
        assert (csr_waddr_o === e.waddr) else begin
            miscompares++;
            $error("[TB] FAIL %s csr_waddr_o got %03h want %03h", tag, csr_waddr_o, e.waddr);
        end
        vectors++;
        assert (csr_wdata_o === e.wdata) else begin
            miscompares++;
            $error("[TB] FAIL %s csr_wdata_o got %08h want %08h", tag, csr_wdata_o, e.wdata);
        end
        vectors++;
        assert (int_assert_o === e.as) else begin
            miscompares++;
            $error("[TB] FAIL %s int_assert_o got %0h want %0h", tag, int_assert_o, e.as);
        end
        vectors++;
        assert (int_addr_o === e.aaddr) else begin
            miscompares++;
            $error("[TB] FAIL %s int_addr_o got %08h want %08h", tag, int_addr_o, e.aaddr);
        end
    endtask

    // Reference model. From the inputs seen at detection and the divider
    // busy length, it builds the expected output trace from the trap rules.
    task automatic buildExpected(input logic [31:0] inst, input logic [31:0] addr,
                                 input logic jf, input logic [31:0] ja,
                                 input logic [7:0] irq, input int busyCycles);
        logic [31:0] ms;
        logic [31:0] newMs;
        logic [31:0] cause;
        logic [31:0] epc;
        int          kind;
        int          idx;
        ms = mstatusReg;
        expQ.delete();

        if (inst == ECALL || inst == EBREAK) kind = 1;
        else if (inst == MRET)               kind = 2;
        else if (irq != 8'h00 && ms[3])      kind = 3;
        else                                 kind = 0;

        if (kind == 0) begin
            expQ.push_back(mkRec(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0));
            return;
        end

        expQ.push_back(mkRec(1'b1, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0));
        for (int k = 0; k < busyCycles; k++) begin
            expQ.push_back(mkRec(1'b1, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0));
        end

        if (kind == 2) begin
            newMs    = ms;
            newMs[3] = ms[7];
            newMs[7] = 1'b1;
            expQ.push_back(mkRec(1'b1, 1'b1, 12'h300, newMs, 1'b0, 32'h0));
            expQ.push_back(mkRec(1'b1, 1'b0, 12'h000, 32'h0, 1'b1, mepcReg));
        end else begin
            idx = 0;
            for (int i = 7; i >= 0; i--) begin
                if (irq[i]) idx = i;
            end
            if (inst == ECALL)       cause = 32'd11;
            else if (inst == EBREAK) cause = 32'd3;
            else                     cause = 32'h8000_0010 + 32'(idx);
            epc      = (kind == 1) ? addr : (jf ? ja : addr);
            newMs    = ms;
            newMs[7] = ms[3];
            newMs[3] = 1'b0;
            expQ.push_back(mkRec(1'b1, 1'b1, 12'h341, epc, 1'b0, 32'h0));
            expQ.push_back(mkRec(1'b1, 1'b1, 12'h342, cause, 1'b0, 32'h0));
            expQ.push_back(mkRec(1'b1, 1'b1, 12'h300, newMs, 1'b0, 32'h0));
            expQ.push_back(mkRec(1'b1, 1'b0, 12'h000, 32'h0, 1'b1, mtvecReg));
        end
    endtask

    // Present a candidate event, then run its sequence. Noise is applied on
    // the inputs the sequencer must ignore.
    task automatic runCase(input string tag, input logic [31:0] inst, input logic [31:0] addr,
                           input logic jf, input logic [31:0] ja,
                           input logic [7:0] irq, input int busyCycles);
        logic busy;
        buildExpected(inst, addr, jf, ja, irq, busyCycles);
        for (int c = 0; c < expQ.size(); c++) begin
            if (c == 0) begin
                applyStimulus(inst, addr, jf, ja, busyCycles > 0, irq);
            end else begin
                if (c < busyCycles)       busy = 1'b1;
                else if (c == busyCycles) busy = 1'b0;
                else                      busy = 1'($urandom_range(0, 1));
                applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom,
                              busy, 8'($urandom_range(0, 255)));
            end
            @(negedge clk_i);
            checkOutput($sformatf("%s[c%0d]", tag, c), expQ[c]);
            @(posedge clk_i);
            #1;
            if (expQ[c].we && expQ[c].waddr == 12'h300) mstatusReg = expQ[c].wdata;
            if (expQ[c].we && expQ[c].waddr == 12'h341) mepcReg    = expQ[c].wdata;
        end
    endtask

    initial begin
        logic [31:0] rInst;
        logic [7:0]  rIrq;
        int          pick;

        mstatusReg = 32'h0000_0008;
        mepcReg    = 32'h0;
        mtvecReg   = 32'h0000_0200;

        // Reset state
        rst_i = 1'b1;
        applyStimulus(NOP, 32'h0, 1'b0, 32'h0, 1'b0, 8'h00);
        repeat (2) @(posedge clk_i);
        #1;
        @(negedge clk_i);
        checkOutput("reset", mkRec(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0));
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // ecall: 0x341<-0x100, 0x342<-11, 0x300<-0x80, redirect to 0x200
        runCase("ecall", ECALL, 32'h100, 1'b0, 32'h0, 8'h00, 0);

        // Interrupt on line 2 while EX redirects: epc comes from the jump target
        mstatusReg = 32'h0000_0008;
        runCase("irq2_jump", NOP, 32'h104, 1'b1, 32'h340, 8'b0000_0100, 0);

        // All requests with MIE clear: nothing happens
        mstatusReg = 32'h0;
        for (int k = 0; k < 3; k++) begin
            runCase("irq_masked", NOP, 32'h108, 1'b0, 32'h0, 8'hFF, 0);
        end

        // mret: 0x300<-0x88, redirect to mepc
        mstatusReg = 32'h0000_0080;
        mepcReg    = 32'h0000_0104;
        runCase("mret", MRET, 32'h200, 1'b0, 32'h0, 8'h00, 0);

        // ebreak while the divider is busy for 3 cycles
        runCase("ebreak_busy", EBREAK, 32'h10C, 1'b0, 32'h0, 8'h00, 3);

        // After an interrupt, MIE is clear and the same request is not re-taken
        mstatusReg = 32'h0000_0008;
        runCase("irq7", NOP, 32'h110, 1'b0, 32'h0, 8'h80, 0);
        runCase("irq_reentry", NOP, 32'h114, 1'b0, 32'h0, 8'h80, 0);

        // Reset in MCAUSE aborts the sequence
        mstatusReg = 32'h0000_0008;
        applyStimulus(ECALL, 32'h120, 1'b0, 32'h0, 1'b0, 8'h00);
        @(negedge clk_i);
        checkOutput("rst_detect", mkRec(1'b1, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0));
        @(posedge clk_i);
        #1;
        applyStimulus(NOP, 32'h124, 1'b0, 32'h0, 1'b0, 8'h00);
        @(negedge clk_i);
        checkOutput("rst_mepc", mkRec(1'b1, 1'b1, 12'h341, 32'h120, 1'b0, 32'h0));
        @(posedge clk_i);
        #1;
        mepcReg = 32'h120;
        applyStimulus(NOP, 32'h124, 1'b0, 32'h0, 1'b0, 8'h00);
        rst_i = 1'b1;
        @(negedge clk_i);
        checkOutput("rst_mcause", mkRec(1'b1, 1'b1, 12'h342, 32'd11, 1'b0, 32'h0));
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(NOP, 32'h128, 1'b0, 32'h0, 1'b0, 8'h00);
            @(negedge clk_i);
            checkOutput($sformatf("rst_after[%0d]", k),
                        mkRec(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0));
            @(posedge clk_i);
            #1;
        end

        // Randomised events, back to back
        for (int n = 0; n < 200; n++) begin
            pick = int'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) mstatusReg = $urandom;
            mtvecReg = $urandom;
            case (pick)
                0:       rInst = ECALL;
                1:       rInst = EBREAK;
                2:       rInst = MRET;
                3:       rInst = NOP;
                default: rInst = $urandom;
            endcase
            if (pick >= 3 || $urandom_range(0, 1) == 1) rIrq = 8'($urandom_range(0, 255));
            else                                        rIrq = 8'h00;
            runCase($sformatf("rnd%0d", n), rInst, $urandom, 1'($urandom_range(0, 1)),
                    $urandom, rIrq, int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/trap_seq.md
Name: trap_seq

Overview:
- Machine-mode trap sequencer for the core. It sits beside the pipeline controller.
- Detects synchronous traps (ecall, ebreak), mret, and external interrupt requests.
- Stalls the pipeline through its hold request and updates mepc, mcause and mstatus over the CSR write port, one CSR per cycle.
- Redirects fetch to the handler address or the return address with a one-cycle assert pulse.

Parameters:
- ADDR_W, 32, instruction address width
- DATA_W, 32, CSR data width
- INT_W, 8, number of external interrupt request lines

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  reset; synchronous and active-high
- inst_i  in  32  instruction currently in ID
- inst_addr_i  in  ADDR_W  address of inst_i
- jump_flag_i  in  1  EX redirect this cycle
- jump_addr_i  in  ADDR_W  EX redirect target
- div_busy_i  in  1  multi-cycle divider in flight
- int_req_i  in  INT_W  external interrupt requests, level, bit0 highest priority
- mtvec_i  in  DATA_W  current mtvec
- mepc_i  in  DATA_W  current mepc
- mstatus_i  in  DATA_W  current mstatus (bit3 MIE, bit7 MPIE)
- hold_flag_o  out  1  stall request to the pipeline controller
- csr_we_o  out  1  CSR write enable
- csr_waddr_o  out  12  CSR write address
- csr_wdata_o  out  DATA_W  CSR write data
- int_assert_o  out  1  one-cycle redirect strobe
- int_addr_o  out  ADDR_W  redirect target, valid while int_assert_o=1

Behaviour:
- Reset: state=IDLE. All outputs 0. Latched cause and epc = 0. A reset in any state aborts the sequence next edge; no further CSR writes occur.
- Decode, exact match on inst_i:
  - ecall = 32'h00000073
  - ebreak = 32'h00100073
  - mret = 32'h30200073
- Interrupt pending = |int_req_i & mstatus_i[3].
- Event priority in IDLE: sync trap (ecall/ebreak) > mret > interrupt. Only one event is accepted per sequence.
- Cause encoding:
  - ecall = 11
  - ebreak = 3
  - interrupt = 32'h8000_0010 + index of the lowest set int_req_i bit
- Latched epc:
  - sync trap: inst_addr_i
  - interrupt: jump_addr_i if jump_flag_i=1, else inst_addr_i
- States:
  - IDLE: on an event, latch cause/epc/kind. Go to WAIT if div_busy_i=1, else to MEPC (trap/interrupt) or MRET_ST (mret).
  - WAIT: hold while div_busy_i=1. Then go to MEPC or MRET_ST.
  - MEPC: we=1, addr 12'h341, data=epc.
  - MCAUSE: we=1, addr 12'h342, data=cause.
  - MSTATUS: we=1, addr 12'h300, data = mstatus_i with bit7 := bit3 and bit3 := 0. Go to ASSERT with target mtvec_i.
  - MRET_ST: we=1, addr 12'h300, data = mstatus_i with bit3 := bit7 and bit7 := 1. Go to ASSERT with target mepc_i.
  - ASSERT: int_assert_o=1, int_addr_o=target, we=0. Go to IDLE.
- Output timing:
  - csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o and int_addr_o are registered (Moore on state). Each asserts only in its state; otherwise 0.
  - hold_flag_o is combinational: 1 in IDLE when an event is detected this cycle, and 1 in every non-IDLE state.
- Latency, interrupt with no divider: detect cycle, then 3 write cycles, then ASSERT. int_assert_o is high 4 cycles after detection.
- Latency, mret: detect, MRET_ST, ASSERT. Assert is 2 cycles after detection.
- mtvec_i and mepc_i are sampled on entry to ASSERT.
- int_req_i changes after acceptance are ignored until the next return to IDLE.
- No event is accepted in the ASSERT cycle. Events are re-evaluated in the following IDLE cycle.
- mstatus_i reflects the completed MSTATUS write one cycle later. This suppresses interrupt re-entry.

Test Plan:
- ecall at inst_addr_i=0x100, mtvec_i=0x200, mstatus_i=0x8:
  - writes 0x341←0x100, 0x342←11, 0x300←0x80
  - int_assert_o=1 with int_addr_o=0x200 four cycles after detection; hold_flag_o high throughout.
- int_req_i=8'b0000_0100, MIE=1, jump_flag_i=1, jump_addr_i=0x340:
  - mepc←0x340, mcause←0x8000_0012.
- int_req_i=0xFF with mstatus_i=0 → no hold, no writes, no assert.
- mret with mstatus_i=0x80, mepc_i=0x104:
  - 0x300←0x88; int_addr_o=0x104 two cycles after detection.
- ebreak with div_busy_i high for 3 cycles:
  - stays in WAIT 3 cycles with hold_flag_o=1, csr_we_o=0; then normal sequence with mcause=3.
- rst_i asserted during MCAUSE:
  - next cycle all outputs 0 and state IDLE; no MSTATUS write and no assert follow.
